// File: rtl/slave_in_pkg.sv
// slave_in_pkg
//   Shared definitions for the bus slave receive path: FSM state encoding,
//   slave select codes and default field widths. The master transmit stage
//   and the slave read-return stage use the same definitions.
package slave_in_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_BURST = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Bus select codes
  localparam logic [1:0] SLV_ID_0 = 2'b00;
  localparam logic [1:0] SLV_ID_1 = 2'b01;
  localparam logic [1:0] SLV_ID_2 = 2'b10;
  localparam logic [1:0] SLV_ID_3 = 2'b11;

  // Default field widths
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  // A command is valid only when exactly one of write/read is requested.
  function automatic logic single_cmd(input logic we, input logic re);
    return we ^ re;
  endfunction

endpackage

// File: rtl/slave_in_serial_shift_rx.sv
// serial_shift_rx
//   Generic LSB-first serial-to-parallel shift register with a bit counter.
//   Each accepted bit enters at the MSB and moves down, so after WIDTH shifts
//   the first bit received sits at bit 0.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   load_i   : clear register and counter (priority over shift_i)
//   shift_i  : accept bit_i this cycle
//   bit_i    : serial input bit
//   value_o  : register contents after this cycle's load/shift; when the
//              final bit of a word is being shifted in this is the complete
//              word, otherwise it is the held word
//   full_o   : the next accepted bit completes the word
//
// WIDTH must be at least 2.
module serial_shift_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] value_o,
  output logic             full_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;

  assign full_o = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = {bit_i, sh_q[WIDTH-1:1]};
      // Counter wraps after a full word so back-to-back words need no reload.
      cnt_d = full_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Exposing the next-state value lets the FSM capture a finished word on
  // the same edge that samples its last bit.
  assign value_o = sh_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_in.sv
// slave_in
//   Serial-to-parallel receive stage on the slave side of the system bus.
//   Deserializes address, burst number and (for writes) data beats, issuing
//   one memory write strobe per beat, or a single read request for reads.
//
// Parameters
//   SLAVE_ID   : select code this instance answers to
//   ADDR_WIDTH : address / burst-number field width
//   DATA_WIDTH : data beat width
//
// Ports
//   clk             : clock, rising edge
//   reset           : asynchronous active-low reset
//   slave_select    : target slave code from the master
//   master_valid    : qualifies the serial bits of this cycle
//   write_en/read_en: command; exactly one must be set to start
//   rx_address      : serial address, LSB first
//   rx_burst_number : serial burst number (N means N+1 beats), LSB first
//   rx_data         : serial data, LSB first, one beat at a time
//   slave_ready     : low only in the DONE cycle (and during reset)
//   rx_done         : one-cycle pulse on transfer completion
//   mem_we          : one-cycle write strobe per beat
//   mem_addr        : write address (base + beat, wrapping)
//   mem_wdata       : write data
//   rd_req          : one-cycle read request pulse
//   rd_addr         : read base address, held until the next request
//   rd_burst        : read burst number, held until the next request
module slave_in
  import slave_in_pkg::*;
#(
  parameter logic [1:0]  SLAVE_ID   = SLV_ID_0,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            slave_select,
  input  logic                  master_valid,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  rx_address,
  input  logic                  rx_burst_number,
  input  logic                  rx_data,
  output logic                  slave_ready,
  output logic                  rx_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] rd_burst
);

  state_t state_q, state_d;

  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;

  logic                  slave_ready_q, slave_ready_d;
  logic                  rx_done_q, rx_done_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] rd_burst_q, rd_burst_d;

  logic start, abort, run;
  logic sh_load, a_shift, b_shift, d_shift;
  logic a_full, b_full, d_full;
  logic [ADDR_WIDTH-1:0] a_value, b_value;
  logic [DATA_WIDTH-1:0] d_value;

  assign start = master_valid && (slave_select == SLAVE_ID) &&
                 single_cmd(write_en, read_en);
  assign abort = !write_en && !read_en;
  assign run   = master_valid && !abort;

  // Shift/clear controls are kept out of the FSM block: the FSM reads the
  // shifters' value outputs, which depend on these enables.
  assign a_shift = ((state_q == ST_IDLE) && start) || ((state_q == ST_ADDR) && run);
  assign b_shift = (state_q == ST_BURST) && run;
  assign d_shift = (state_q == ST_DATA) && run;
  assign sh_load = ((state_q == ST_IDLE) && !start) ||
                   (state_q == ST_DONE) ||
                   ((state_q != ST_IDLE) && abort) ||
                   (state_q > ST_DONE);

  serial_shift_rx #(.WIDTH(ADDR_WIDTH)) u_addr_rx (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (sh_load),
    .shift_i(a_shift),
    .bit_i  (rx_address),
    .value_o(a_value),
    .full_o (a_full)
  );

  serial_shift_rx #(.WIDTH(ADDR_WIDTH)) u_burst_rx (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (sh_load),
    .shift_i(b_shift),
    .bit_i  (rx_burst_number),
    .value_o(b_value),
    .full_o (b_full)
  );

  serial_shift_rx #(.WIDTH(DATA_WIDTH)) u_data_rx (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (sh_load),
    .shift_i(d_shift),
    .bit_i  (rx_data),
    .value_o(d_value),
    .full_o (d_full)
  );

  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    beat_d      = beat_q;
    rx_done_d   = 1'b0;
    mem_we_d    = 1'b0;
    rd_req_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_addr_d   = rd_addr_q;
    rd_burst_d  = rd_burst_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_wr_d = write_en;
          beat_d   = '0;
          state_d  = a_full ? ST_BURST : ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (master_valid && a_full) begin
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (master_valid && b_full) begin
          if (cmd_wr_q) begin
            state_d = ST_DATA;
          end else begin
            rd_req_d   = 1'b1;
            rx_done_d  = 1'b1;
            rd_addr_d  = a_value;
            rd_burst_d = b_value;
            state_d    = ST_DONE;
          end
        end
      end

      ST_DATA: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (master_valid && d_full) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = a_value + beat_q;
          mem_wdata_d = d_value;
          beat_d      = beat_q + ADDR_WIDTH'(1);
          if (beat_q == b_value) begin
            rx_done_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    slave_ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cmd_wr_q      <= 1'b0;
      beat_q        <= '0;
      slave_ready_q <= 1'b0;
      rx_done_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      rd_burst_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_wr_q      <= cmd_wr_d;
      beat_q        <= beat_d;
      slave_ready_q <= slave_ready_d;
      rx_done_q     <= rx_done_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      rd_burst_q    <= rd_burst_d;
    end
  end

  assign slave_ready = slave_ready_q;
  assign rx_done     = rx_done_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_burst    = rd_burst_q;

endmodule

// File: tb/tb_slave_in.sv
// tb_slave_in
//   Self-checking bench for slave_in. A transfer is described by its command,
//   address, burst and beat data; the bench serializes it bit by bit (with
//   optional pauses, abort or reset) and predicts every output each cycle
//   from the count of bits accepted so far.
module tb_slave_in;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam logic [1:0] MY_ID = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    slave_select;
  logic          master_valid, write_en, read_en;
  logic          rx_address, rx_burst_number, rx_data;
  logic          slave_ready, rx_done, mem_we, rd_req;
  logic [AW-1:0] mem_addr, rd_addr, rd_burst;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  slave_in #(
    .SLAVE_ID  (MY_ID),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .slave_select   (slave_select),
    .master_valid   (master_valid),
    .write_en       (write_en),
    .read_en        (read_en),
    .rx_address     (rx_address),
    .rx_burst_number(rx_burst_number),
    .rx_data        (rx_data),
    .slave_ready    (slave_ready),
    .rx_done        (rx_done),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_burst       (rd_burst)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] bdata[$];
  logic [AW-1:0] m_rd_addr, m_rd_burst;

  task automatic drive_idle();
    master_valid    = 1'b0;
    write_en        = 1'b0;
    read_en         = 1'b0;
    slave_select    = 2'($urandom);
    rx_address      = 1'($urandom);
    rx_burst_number = 1'($urandom);
    rx_data         = 1'($urandom);
  endtask

  // Idle cycles: nothing may fire, slave is ready, read results are held.
  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_we, rx_done, rd_req, slave_ready} !== 4'b0001) begin
        n_bad++;
        $display("FAIL %s idle strobes: got we/done/rdreq/ready=%b%b%b%b required 0001",
                 nm, mem_we, rx_done, rd_req, slave_ready);
      end
      n_cmp++;
      if (rd_addr !== m_rd_addr || rd_burst !== m_rd_burst) begin
        n_bad++;
        $display("FAIL %s idle rd_hold: got addr=%0d burst=%0d required addr=%0d burst=%0d",
                 nm, rd_addr, rd_burst, m_rd_addr, m_rd_burst);
      end
    end
  endtask

  // Serialize one transfer and check outputs every cycle.
  // pct: random pause percentage; pause_at/pause_len: forced pause before
  // bit pause_at; abort_at / rst_at: bit index to abort / reset at (-1 none).
  // done_cyc: cycle (start cycle = 0) in which rx_done was expected.
  task automatic xfer(input string nm, input bit wr, input logic [AW-1:0] addr,
                      input logic [AW-1:0] burst, input int pct, input int pause_at,
                      input int pause_len, input int abort_at, input int rst_at,
                      output int done_cyc);
    int nbits, b, cyc, forced, beat, db;
    bit pz, ab, smp, e_we, e_done, e_rd, aborted;
    logic [AW-1:0] ea;
    nbits    = 2 * AW + (wr ? DW * (int'(burst) + 1) : 0);
    b        = 0;
    cyc      = 0;
    forced   = 0;
    done_cyc = -1;
    aborted  = 1'b0;
    while (b < nbits) begin
      if (b == rst_at) begin
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({slave_ready, rx_done, mem_we, rd_req} !== 4'b0000 || mem_addr !== '0 ||
            mem_wdata !== '0 || rd_addr !== '0 || rd_burst !== '0) begin
          n_bad++;
          $display("FAIL %s async_reset: got ready=%b done=%b we=%b rdreq=%b maddr=%0d wdata=%0h raddr=%0d rburst=%0d required all 0",
                   nm, slave_ready, rx_done, mem_we, rd_req, mem_addr, mem_wdata, rd_addr, rd_burst);
        end
        m_rd_addr  = '0;
        m_rd_burst = '0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      ab = (b == abort_at);
      pz = 1'b0;
      if (!ab && b > 0) begin
        if (b == pause_at && forced < pause_len) begin
          pz = 1'b1;
          forced++;
        end else if ($urandom_range(99) < pct) begin
          pz = 1'b1;
        end
      end
      master_valid    = !pz;
      slave_select    = MY_ID;
      write_en        = ab ? 1'b0 : wr;
      read_en         = ab ? 1'b0 : !wr;
      rx_address      = 1'($urandom);
      rx_burst_number = 1'($urandom);
      rx_data         = 1'($urandom);
      if (!pz && !ab) begin
        if (b < AW) rx_address = 1'(addr >> b);
        else if (b < 2 * AW) rx_burst_number = 1'(burst >> (b - AW));
        else begin
          db      = b - 2 * AW;
          rx_data = 1'(bdata[db / DW] >> (db % DW));
        end
      end
      @(posedge clk); #1;
      smp = !pz && !ab;
      if (smp) b++;
      cyc++;
      e_done = smp && (b == nbits);
      e_we   = wr && smp && (b > 2 * AW) && (((b - 2 * AW) % DW) == 0);
      e_rd   = !wr && e_done;
      if (e_done) done_cyc = cyc;
      if (e_rd) begin
        m_rd_addr  = addr;
        m_rd_burst = burst;
      end
      n_cmp++;
      if ({mem_we, rx_done, rd_req, slave_ready} !== {e_we, e_done, e_rd, !e_done}) begin
        n_bad++;
        $display("FAIL %s cyc%0d strobes: got we/done/rdreq/ready=%b%b%b%b required %b%b%b%b",
                 nm, cyc, mem_we, rx_done, rd_req, slave_ready, e_we, e_done, e_rd, !e_done);
      end
      if (e_we) begin
        beat = (b - 2 * AW) / DW - 1;
        ea   = addr + AW'(beat);
        n_cmp++;
        if (mem_addr !== ea || mem_wdata !== bdata[beat]) begin
          n_bad++;
          $display("FAIL %s beat%0d write: got addr=%0d data=%0h required addr=%0d data=%0h",
                   nm, beat, mem_addr, mem_wdata, ea, bdata[beat]);
        end
      end
      n_cmp++;
      if (rd_addr !== m_rd_addr || rd_burst !== m_rd_burst) begin
        n_bad++;
        $display("FAIL %s cyc%0d rd_regs: got addr=%0d burst=%0d required addr=%0d burst=%0d",
                 nm, cyc, rd_addr, rd_burst, m_rd_addr, m_rd_burst);
      end
      if (ab) begin
        aborted = 1'b1;
        break;
      end
      if (cyc > 5000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout: got %0d of %0d bits accepted in %0d cycles required all",
                 nm, b, nbits, cyc);
        break;
      end
    end
    if (aborted) begin
      idle({nm, "_post_abort"}, 6);
    end else if (done_cyc >= 0) begin
      // DONE cycle: a start-looking request here must be ignored.
      master_valid = 1'b1;
      slave_select = MY_ID;
      write_en     = 1'b1;
      read_en      = 1'b0;
      rx_address   = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_we, rx_done, rd_req, slave_ready} !== 4'b0001) begin
        n_bad++;
        $display("FAIL %s done_exit: got we/done/rdreq/ready=%b%b%b%b required 0001",
                 nm, mem_we, rx_done, rd_req, slave_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    m_rd_addr  = '0;
    m_rd_burst = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({slave_ready, rx_done, mem_we, rd_req} !== 4'b0000 || mem_addr !== '0 ||
        mem_wdata !== '0 || rd_addr !== '0 || rd_burst !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%b done=%b we=%b rdreq=%b maddr=%0d wdata=%0h raddr=%0d rburst=%0d required all 0",
               slave_ready, rx_done, mem_we, rd_req, mem_addr, mem_wdata, rd_addr, rd_burst);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (slave_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got slave_ready=%b required 1", slave_ready);
    end
  endtask

  task automatic test_single_write();
    int dc;
    bdata = '{8'h09};
    xfer("single_wr", 1'b1, 12'(5459), 12'd0, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + DW) begin
      n_bad++;
      $display("FAIL single_wr latency: got %0d required %0d", dc, 2 * AW + DW);
    end
    idle("single_wr", 3);
  endtask

  task automatic test_burst_write();
    int dc;
    bdata = '{8'h11, 8'h22, 8'h33};
    xfer("burst_wr", 1'b1, 12'd4094, 12'd2, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + 3 * DW) begin
      n_bad++;
      $display("FAIL burst_wr latency: got %0d required %0d", dc, 2 * AW + 3 * DW);
    end
    idle("burst_wr", 3);
  endtask

  task automatic test_read();
    int dc;
    xfer("read", 1'b0, 12'd100, 12'd5, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW) begin
      n_bad++;
      $display("FAIL read latency: got %0d required %0d", dc, 2 * AW);
    end
    idle("read", 3);
    bdata = '{8'hA5};
    xfer("read_hold_wr", 1'b1, 12'd7, 12'd0, 0, -1, 0, -1, -1, dc);
    idle("read_hold", 2);
  endtask

  task automatic test_ignored();
    int dc;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    sa = mem_addr;
    sd = mem_wdata;
    for (int i = 0; i < 60; i++) begin
      master_valid    = 1'b1;
      slave_select    = (i < 30) ? 2'b01 : MY_ID;
      write_en        = 1'b1;
      read_en         = (i < 30) ? 1'($urandom) : 1'b1;
      if (i < 30) read_en = 1'b0;
      rx_address      = 1'($urandom);
      rx_burst_number = 1'($urandom);
      rx_data         = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_we, rx_done, rd_req, slave_ready} !== 4'b0001 ||
          mem_addr !== sa || mem_wdata !== sd) begin
        n_bad++;
        $display("FAIL ignored cyc%0d: got we/done/rdreq/ready=%b%b%b%b maddr=%0d wdata=%0h required 0001 maddr=%0d wdata=%0h",
                 i, mem_we, rx_done, rd_req, slave_ready, mem_addr, mem_wdata, sa, sd);
      end
    end
    bdata = '{8'h5C};
    xfer("after_ignored", 1'b1, 12'd321, 12'd0, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + DW) begin
      n_bad++;
      $display("FAIL after_ignored latency: got %0d required %0d", dc, 2 * AW + DW);
    end
    idle("after_ignored", 2);
  endtask

  task automatic test_pause_abort();
    int dc;
    bdata = '{8'h09};
    xfer("pause", 1'b1, 12'(5459), 12'd0, 0, 5, 3, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + DW + 3) begin
      n_bad++;
      $display("FAIL pause latency: got %0d required %0d", dc, 2 * AW + DW + 3);
    end
    idle("pause", 2);
    bdata = '{8'hC3, 8'h3C};
    xfer("abort_beat1", 1'b1, 12'd50, 12'd1, 0, -1, 0, 2 * AW + DW + 3, -1, dc);
    bdata = '{8'h77};
    xfer("abort_beat0", 1'b1, 12'd60, 12'd0, 0, -1, 0, 2 * AW + 4, -1, dc);
    xfer("abort_addr", 1'b0, 12'd61, 12'd3, 0, -1, 0, 6, -1, dc);
    bdata = '{8'hE1};
    xfer("after_abort", 1'b1, 12'd62, 12'd0, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + DW) begin
      n_bad++;
      $display("FAIL after_abort latency: got %0d required %0d", dc, 2 * AW + DW);
    end
    idle("after_abort", 2);
  endtask

  task automatic test_reset_mid();
    int dc;
    xfer("pre_reset_rd", 1'b0, 12'd999, 12'd9, 0, -1, 0, -1, -1, dc);
    bdata = '{8'hF0};
    xfer("pre_reset_wr", 1'b1, 12'd1234, 12'd0, 0, -1, 0, -1, -1, dc);
    bdata = '{8'h12, 8'h34};
    xfer("reset_in_burst", 1'b1, 12'd2000, 12'd1, 0, -1, 0, -1, AW + 5, dc);
    bdata = '{8'h09};
    xfer("post_reset_wr", 1'b1, 12'(5459), 12'd0, 0, -1, 0, -1, -1, dc);
    n_cmp++;
    if (dc !== 2 * AW + DW) begin
      n_bad++;
      $display("FAIL post_reset latency: got %0d required %0d", dc, 2 * AW + DW);
    end
    idle("post_reset", 2);
  endtask

  task automatic test_back_to_back();
    int dc;
    bit wr;
    logic [AW-1:0] a, bu;
    for (int t = 0; t < 6; t++) begin
      wr = 1'($urandom);
      a  = AW'($urandom);
      bu = AW'($urandom_range(3));
      bdata.delete();
      for (int i = 0; i <= int'(bu); i++) bdata.push_back(DW'($urandom));
      xfer("b2b", wr, a, bu, 25, -1, 0, -1, -1, dc);
    end
    idle("b2b", 2);
  endtask

  task automatic test_random();
    int dc;
    bit wr;
    logic [AW-1:0] a, bu;
    for (int t = 0; t < 20; t++) begin
      wr = 1'($urandom);
      a  = AW'($urandom);
      bu = AW'($urandom_range(4));
      bdata.delete();
      for (int i = 0; i <= int'(bu); i++) bdata.push_back(DW'($urandom));
      if ($urandom_range(3) == 0)
        xfer("rand_abort", wr, a, bu, 15, -1, 0,
             int'($urandom_range(1, 2 * AW + (wr ? DW : 0) - 1)), -1, dc);
      else
        xfer("rand", wr, a, bu, 15, -1, 0, -1, -1, dc);
      idle("rand", int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_write();
    test_burst_write();
    test_read();
    test_ignored();
    test_pause_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_in.md
# slave_in

Serial-to-parallel receive stage on the slave side of the system bus. It sits directly downstream of the master's transmit stage: it watches `slave_select`/`master_valid`, deserializes the one-bit address, burst-number and data lines, and turns them into parallel memory write strobes. For a read, it emits a single read request that the slave's read-return stage consumes. It drives `slave_ready` and `rx_done` back to the master.

## Interface
- `SLAVE_ID`, 2'b00, bus select code this instance answers to
- `ADDR_WIDTH`, 12, address and burst-number field width
- `DATA_WIDTH`, 8, data beat width
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `slave_select`  input  2  target slave code from master
- `master_valid`  input  1  qualifies the serial bit on the current cycle
- `write_en`  input  1  write command
- `read_en`  input  1  read command
- `rx_address`  input  1  serial address, LSB first
- `rx_burst_number`  input  1  serial burst number, LSB first
- `rx_data`  input  1  serial data, LSB first, one beat at a time
- `slave_ready`  output  1  slave can accept or continue a transfer
- `rx_done`  output  1  one-cycle pulse, transfer completed
- `mem_we`  output  1  one-cycle write strobe per beat
- `mem_addr`  output  ADDR_WIDTH  write address for `mem_we`
- `mem_wdata`  output  DATA_WIDTH  write data for `mem_we`
- `rd_req`  output  1  one-cycle read request pulse
- `rd_addr`  output  ADDR_WIDTH  read base address, held until next request
- `rd_burst`  output  ADDR_WIDTH  read burst number, held until next request

## Operation
- States: `IDLE`, `ADDR`, `BURST`, `DATA`, `DONE`.
- A transfer starts in `IDLE` when `master_valid=1`, `slave_select==SLAVE_ID`, and exactly one of `write_en`/`read_en` is 1. That start cycle samples address bit 0 and moves the FSM to `ADDR`.
- If both enables are high, or the select does not match, the slave stays in `IDLE` and does nothing.
- Field order is fixed: address (ADDR_WIDTH bits on `rx_address`), then burst (ADDR_WIDTH bits on `rx_burst_number`), then data (DATA_WIDTH bits per beat on `rx_data`, write only). Only the line for the current field is sampled.
- Bits are sampled only on cycles with `master_valid=1`. A cycle with `master_valid=0` pauses the transfer and holds all counters.
- The command is latched at start. If `write_en` and `read_en` are both 0 in any non-`IDLE` state, the transfer aborts: return to `IDLE`, no `rx_done`, no further `mem_we`.
- Burst value N means N+1 beats. Beat k is written to (base + k) mod 2^ADDR_WIDTH; the address wraps.
- Write: after each beat's last bit, pulse `mem_we` with that beat's `mem_addr`/`mem_wdata`. The last beat also pulses `rx_done` and enters `DONE`.
- Read: after the last burst bit, pulse `rd_req` and `rx_done` together, load `rd_addr`/`rd_burst`, and enter `DONE`. There is no `DATA` state for reads.
- `DONE` lasts 1 cycle, then the FSM returns to `IDLE`.
- `slave_ready` is 1 in `IDLE`, `ADDR`, `BURST` and `DATA`, and 0 in `DONE`.

## Timing
- Reset (asynchronous, active-low): FSM goes to `IDLE`, all counters and shift registers go to 0, and every output is 0 except `slave_ready`. `slave_ready` is 0 while reset is asserted and 1 in the first cycle after release.
- Reset mid-transfer discards the partial transfer with no strobe.
- All outputs are registered.
- `mem_we`/`rx_done` assert the cycle after the sampling edge of the final data bit of a beat. `rd_req` timing is the same relative to the final burst bit.
- With no pauses, a single-beat write gives `mem_we` and `rx_done` exactly 2·ADDR_WIDTH + DATA_WIDTH cycles after the start edge (32 at defaults).
- With no pauses, consecutive beats strobe every DATA_WIDTH cycles.
- A new start is accepted on the cycle after `DONE`.

## Structure
- Shared package: state encoding, the `SLAVE_ID` select codes, and the default field widths, shared with the master stage and the slave read-return stage.
- Sub-module `serial_shift_rx`: a generic LSB-first shift register with a bit counter and `load`/`shift`/`full` outputs. It is reused for the address, burst and data fields.
- Everything else lives in one FSM module.

## Test plan
- Single write: SLAVE_ID=2, sel=2, write, addr=12'd5459 (truncated to 1363), burst=0, data=8'h09, continuous valid -> one `mem_we` at cycle 32 with `mem_addr`=1363 and `mem_wdata`=0x09, `rx_done` in the same cycle, `slave_ready` low 1 cycle.
- Burst write: addr=4094, burst=2, data 0x11/0x22/0x33 -> three `mem_we` 8 cycles apart at addr 4094, 4095, 0 (wrap); `rx_done` only with the third.
- Read: addr=100, burst=5 -> `rd_req` and `rx_done` at cycle 24 with `rd_addr`=100, `rd_burst`=5; no `mem_we`.
- Select mismatch or both enables set: sel=1 with SLAVE_ID=2, or write_en=read_en=1 -> no state change, outputs stay at 0.
- Pauses and abort: `master_valid` low for 3 cycles mid-address -> completion delayed by exactly 3 cycles, same values. Dropping both enables mid-data -> return to `IDLE`, no `mem_we`, no `rx_done`.
- Async reset pulse during the `BURST` state -> outputs go to 0 immediately, and a following clean single write completes correctly.
